// File: rtl/defuzzy_scheduler_pkg.sv
// Shared definitions for the defuzzification scheduler: widths, job size and FSM encoding.
package defuzzy_scheduler_pkg;

    localparam int CFNP_DW       = 16;
    localparam int DF_INPUT_SIZE = 5;
    localparam int NUM_REQ       = 2;
    localparam int ADDR_W        = $clog2(DF_INPUT_SIZE);

    typedef enum logic [1:0] {
        DS_IDLE   = 2'd0,
        DS_CLEAR  = 2'd1,
        DS_RUN    = 2'd2,
        DS_RESULT = 2'd3
    } ds_state_t;

    // With two requesters the next round-robin pointer is simply the other ID.
    function automatic logic next_ptr(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/defuzzy_scheduler_if.sv
// Requester-side bus of the scheduler: request/grant, buffer read steering and tagged result port.
interface defuzzy_scheduler_if;
    import defuzzy_scheduler_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        gnt;
    logic                      src_sel;
    logic [ADDR_W-1:0]         src_addra;
    logic signed [CFNP_DW-1:0] src0_idata;
    logic signed [CFNP_DW-1:0] src1_idata;
    logic                      res_valid;
    logic                      res_id;
    logic signed [CFNP_DW-1:0] res_data;
    logic                      res_err;
    logic                      res_ready;

    modport master (
        output req, src0_idata, src1_idata, res_ready,
        input  gnt, src_sel, src_addra, res_valid, res_id, res_data, res_err
    );

    modport slave (
        input  req, src0_idata, src1_idata, res_ready,
        output gnt, src_sel, src_addra, res_valid, res_id, res_data, res_err
    );

endinterface

// File: rtl/defuzzy_scheduler_rr_arbiter2.sv
// Combinational two-way round-robin arbiter; the pointer register is owned by the caller.
module rr_arbiter2
    import defuzzy_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_id
);

    // Pointer holder wins; otherwise the other requester, if it is asking.
    always_comb begin
        grant    = '0;
        grant_id = 1'b0;
        if (en) begin
            if (req[ptr]) begin
                grant_id = ptr;
                grant    = NUM_REQ'(1) << ptr;
            end else if (req[~ptr]) begin
                grant_id = ~ptr;
                grant    = NUM_REQ'(1) << (~ptr);
            end
        end
    end

endmodule

// File: rtl/defuzzy_scheduler.sv
// Time-shares one defuzzification engine between two requesters and returns ID-tagged results.
module defuzzy_scheduler
    import defuzzy_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    defuzzy_scheduler_if.slave        bus,
    output logic                      eng_rst,
    output logic                      eng_start,
    input  logic [ADDR_W-1:0]         eng_addra,
    output logic signed [CFNP_DW-1:0] eng_idata,
    input  logic signed [CFNP_DW-1:0] eng_odata,
    input  logic                      eng_done,
    output logic                      busy
);

    localparam int               TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    ds_state_t                 state;
    ds_state_t                 state_nxt;
    logic                      rr_ptr;
    logic                      src_sel_q;
    logic [TMO_W-1:0]          tmo_cnt;
    logic signed [CFNP_DW-1:0] res_data_q;
    logic                      res_err_q;
    logic                      arb_en;
    logic [NUM_REQ-1:0]        arb_grant;
    logic                      arb_id;
    logic                      tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    rr_arbiter2 u_arb (
        .req      (bus.req),
        .ptr      (rr_ptr),
        .en       (arb_en),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RESULT leaves only after the consumer takes the result.
    always_comb begin
        state_nxt = state;
        case (state)
            DS_IDLE:   if (arb_grant != '0)       state_nxt = DS_CLEAR;
            DS_CLEAR:                             state_nxt = DS_RUN;
            DS_RUN:    if (eng_done || tmo_hit)   state_nxt = DS_RESULT;
            DS_RESULT: if (bus.res_ready)         state_nxt = DS_IDLE;
            default:                              state_nxt = DS_IDLE;
        endcase
    end

    // State-decoded outputs; the engine is held in reset outside RUN except while idle.
    always_comb begin
        eng_rst       = rst;
        eng_start     = 1'b0;
        bus.res_valid = 1'b0;
        arb_en        = 1'b0;
        case (state)
            DS_IDLE:   arb_en = ~rst;
            DS_CLEAR:  eng_rst = 1'b1;
            DS_RUN:    eng_start = 1'b1;
            DS_RESULT: begin
                eng_rst       = 1'b1;
                bus.res_valid = 1'b1;
            end
            default:   eng_rst = 1'b1;
        endcase
        busy = (state != DS_IDLE);
    end

    // Job bookkeeping: pointer and source latch on grant, timeout count, result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            src_sel_q  <= 1'b0;
            tmo_cnt    <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (arb_grant != '0) begin
                        src_sel_q <= arb_id;
                        rr_ptr    <= next_ptr(arb_id);
                    end
                end
                DS_CLEAR: tmo_cnt <= '0;
                DS_RUN: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (eng_done) begin
                        res_data_q <= eng_odata;
                        res_err_q  <= 1'b0;
                    end else if (tmo_hit) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = arb_grant;
    assign bus.src_sel   = src_sel_q;
    assign bus.src_addra = eng_addra;
    assign bus.res_id    = src_sel_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign eng_idata     = src_sel_q ? bus.src1_idata : bus.src0_idata;

endmodule
